// File: rtl/wb_bram_bist_if.sv
// Pipelined Wishbone B4 link between the BRAM self-test master and one BRAM port.
interface wb_bram_bist_if #(
    parameter int AW = 10,
    parameter int DW = 32
) ();
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic            stall;
    logic            ack;
    logic [DW-1:0]   dat_r;

    modport master (output cyc, stb, we, adr, dat_w, sel, input stall, ack, dat_r);
    modport slave  (input cyc, stb, we, adr, dat_w, sel, output stall, ack, dat_r);
endinterface

// File: rtl/wb_bram_bist.sv
// BRAM self-test: fills every word with P(a) = a ^ SEED over pipelined Wishbone,
// reads it all back, and reports error count and first failing address.
//
// state  | meaning
// IDLE   | waiting for a start pulse
// WRITE  | issuing fill writes, one per unstalled cycle
// WDRAIN | stb low, waiting for the remaining write acks
// READ   | one cyc-low gap cycle on entry from WDRAIN, then issuing reads
// RDRAIN | stb low, waiting for the remaining read acks
// DONE   | publish results, back to IDLE next cycle
module wb_bram_bist #(
    parameter int          AW   = 10,
    parameter int          DW   = 32,
    parameter logic [31:0] SEED = 32'hA5A5A5A5
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_start,
    input  logic           i_skip_fill,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_pass,
    output logic [AW:0]    o_err_count,
    output logic [AW-1:0]  o_err_addr,
    wb_bram_bist_if.master wb
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WDRAIN,
        S_READ,
        S_RDRAIN,
        S_DONE
    } state_t;

    localparam logic [DW-1:0] KEY = DW'(SEED);

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return DW'(a) ^ KEY;
    endfunction

    state_t        state;
    logic [AW:0]   outst;
    logic [AW-1:0] ack_addr;

    logic          accept;
    logic          ack_v;
    logic          last_acc;
    logic          rd_ack;
    logic          mismatch;
    logic [AW:0]   outst_nxt;

    assign wb.sel = '1;

    // Acks outside a cycle or with nothing outstanding are stray and must not
    // underflow the outstanding count.
    always_comb begin
        accept    = wb.stb && !wb.stall;
        ack_v     = wb.ack && wb.cyc && (outst != '0);
        last_acc  = accept && (wb.adr == '1);
        rd_ack    = ack_v && ((state == S_READ) || (state == S_RDRAIN));
        mismatch  = rd_ack && (wb.dat_r != pattern(ack_addr));
        outst_nxt = outst + {{AW{1'b0}}, accept} - {{AW{1'b0}}, ack_v};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            outst       <= '0;
            ack_addr    <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_err_count <= '0;
            o_err_addr  <= '0;
            wb.cyc      <= 1'b0;
            wb.stb      <= 1'b0;
            wb.we       <= 1'b0;
            wb.adr      <= '0;
            wb.dat_w    <= '0;
        end else begin
            outst <= outst_nxt;
            if (rd_ack) begin
                ack_addr <= ack_addr + 1'b1;
            end
            if (mismatch) begin
                if (o_err_count != '1) begin
                    o_err_count <= o_err_count + 1'b1;
                end
                if (o_err_count == '0) begin
                    o_err_addr <= ack_addr;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_done      <= 1'b0;
                        o_pass      <= 1'b0;
                        o_err_count <= '0;
                        o_err_addr  <= '0;
                        ack_addr    <= '0;
                        o_busy      <= 1'b1;
                        wb.cyc      <= 1'b1;
                        wb.stb      <= 1'b1;
                        wb.adr      <= '0;
                        if (i_skip_fill) begin
                            wb.we    <= 1'b0;
                            wb.dat_w <= '0;
                            state    <= S_READ;
                        end else begin
                            wb.we    <= 1'b1;
                            wb.dat_w <= pattern('0);
                            state    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (last_acc) begin
                        wb.stb <= 1'b0;
                        state  <= S_WDRAIN;
                    end else if (accept) begin
                        wb.adr   <= wb.adr + 1'b1;
                        wb.dat_w <= pattern(wb.adr + 1'b1);
                    end
                end
                S_WDRAIN: begin
                    if (outst_nxt == '0) begin
                        wb.cyc   <= 1'b0;
                        wb.we    <= 1'b0;
                        wb.dat_w <= '0;
                        wb.adr   <= '0;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    // stb low here only on the gap cycle after the fill phase
                    if (!wb.stb) begin
                        wb.cyc <= 1'b1;
                        wb.stb <= 1'b1;
                    end else if (last_acc) begin
                        wb.stb <= 1'b0;
                        state  <= S_RDRAIN;
                    end else if (accept) begin
                        wb.adr <= wb.adr + 1'b1;
                    end
                end
                S_RDRAIN: begin
                    if (outst_nxt == '0) begin
                        wb.cyc <= 1'b0;
                        wb.adr <= '0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_pass <= (o_err_count == '0);
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_bram_bist.sv
// Self-checking bench for wb_bram_bist: randomized BRAM slave, scoreboard of
// expected bus requests and results, and a reference model of the memory test.
module tb_wb_bram_bist;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
    localparam logic [DW-1:0] KEY = 8'hA5;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    logic i_start = 1'b0;
    logic i_skip_fill = 1'b0;
    logic o_busy, o_done, o_pass;
    logic [AW:0]   o_err_count;
    logic [AW-1:0] o_err_addr;

    wb_bram_bist_if #(.AW(AW), .DW(DW)) wb ();

    wb_bram_bist #(.AW(AW), .DW(DW), .SEED(32'hA5A5A5A5)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_start     (i_start),
        .i_skip_fill (i_skip_fill),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pass      (o_pass),
        .o_err_count (o_err_count),
        .o_err_addr  (o_err_addr),
        .wb          (wb)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int cnt; int addr; int pass; int nwr; int nrd; } res_t;
    typedef struct { int due; logic [DW-1:0] data; } ack_t;

    wr_t  exp_wr[$];
    int   exp_rd[$];
    res_t exp_res[$];

    int n_checks = 0;
    int n_pass = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] av;
        av = a[DW-1:0];
        return av ^ KEY;
    endfunction

    // Slave model: BRAM with optional random stall and 1-3 cycle in-order acks
    logic [DW-1:0] mem [N];
    bit   corrupt [N];
    logic [DW-1:0] ref_mem [N];
    bit   rnd_mode = 0;
    bit   zero_req = 0;
    logic stray = 1'b0;
    logic ack_sched = 1'b0;
    logic stall = 1'b0;
    logic [DW-1:0] rdata = '0;
    ack_t ackq[$];
    int   cyc_n = 0;
    int   last_due = 0;

    assign wb.ack   = ack_sched | stray;
    assign wb.dat_r = rdata;
    assign wb.stall = stall;

    always @(negedge i_clk) begin : slave
        int   d;
        ack_t e;
        cyc_n++;
        ack_sched = 1'b0;
        if (zero_req) for (int a = 0; a < N; a++) mem[a] = '0;
        if (!i_reset_n) begin
            ackq.delete();
            stall = 1'b0;
        end else begin
            if (ackq.size() > 0 && ackq[0].due == cyc_n) begin
                ack_sched = 1'b1;
                rdata = ackq[0].data;
                void'(ackq.pop_front());
            end
            stall = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (wb.stb && !stall) begin
                d = rnd_mode ? $urandom_range(1, 3) : 1;
                e.due = cyc_n + d;
                if (e.due <= last_due) e.due = last_due + 1;
                last_due = e.due;
                if (wb.we) begin
                    mem[wb.adr] = wb.dat_w;
                    e.data = '0;
                end else begin
                    e.data = corrupt[wb.adr] ? '0 : mem[wb.adr];
                end
                ackq.push_back(e);
            end
        end
    end

    // Monitor: compares every presented request and every completion against the scoreboard
    int   mon_wr_acks = 0, mon_rd_acks = 0, gap_cnt = 0;
    bit   gap_on = 0;
    logic p_cyc = 1'b0, p_we = 1'b0, p_done = 1'b0;

    always @(negedge i_clk) begin : monitor
        res_t r;
        #1;
        if (!i_reset_n) begin
            p_cyc = 1'b0; p_we = 1'b0; p_done = 1'b0; gap_on = 0;
        end else begin
            if (i_start && !o_busy) begin
                mon_wr_acks = 0;
                mon_rd_acks = 0;
            end
            if (wb.ack && wb.cyc) begin
                if (wb.we) mon_wr_acks++;
                else mon_rd_acks++;
            end
            if (wb.stb) begin
                if (wb.we) begin
                    if (exp_wr.size() == 0) check("wr_expected", exp_wr.size(), 1);
                    else begin
                        check("wr_addr", wb.adr, exp_wr[0].addr);
                        check("wr_data", wb.dat_w, exp_wr[0].data);
                        if (!wb.stall) void'(exp_wr.pop_front());
                    end
                end else begin
                    if (exp_rd.size() == 0) check("rd_expected", exp_rd.size(), 1);
                    else begin
                        check("rd_addr", wb.adr, exp_rd[0]);
                        if (!wb.stall) void'(exp_rd.pop_front());
                    end
                end
            end
            if (!o_busy) gap_on = 0;
            else if (p_cyc && !wb.cyc && p_we) begin gap_on = 1; gap_cnt = 1; end
            else if (gap_on && !wb.cyc) gap_cnt++;
            else if (gap_on && wb.cyc) begin
                check("phase_gap", gap_cnt, 1);
                gap_on = 0;
            end
            if (o_done && !p_done) begin
                if (exp_res.size() == 0) check("res_expected", exp_res.size(), 1);
                else begin
                    r = exp_res.pop_front();
                    check("err_count", o_err_count, r.cnt);
                    check("err_addr", o_err_addr, r.addr);
                    check("pass", o_pass, r.pass);
                    check("busy_at_done", o_busy, 0);
                    check("wr_acks", mon_wr_acks, r.nwr);
                    check("rd_acks", mon_rd_acks, r.nrd);
                    check("wr_left", exp_wr.size(), 0);
                    check("rd_left", exp_rd.size(), 0);
                end
            end
            p_cyc = wb.cyc; p_we = wb.we; p_done = o_done;
        end
    end

    // Reference model: expected requests and result of one self-test pass
    task automatic expect_run(input bit skip);
        int err = 0;
        int first = 0;
        logic [DW-1:0] stored, got;
        wr_t w;
        res_t r;
        for (int a = 0; a < N; a++) begin
            if (!skip) begin
                w.addr = a; w.data = pat(a);
                exp_wr.push_back(w);
            end
            exp_rd.push_back(a);
            stored = skip ? ref_mem[a] : pat(a);
            got = corrupt[a] ? '0 : stored;
            if (got != pat(a)) begin
                if (err == 0) first = a;
                err++;
            end
        end
        if (!skip) for (int a = 0; a < N; a++) ref_mem[a] = pat(a);
        r.cnt  = (err > (2 * N - 1)) ? (2 * N - 1) : err;
        r.addr = first;
        r.pass = (err == 0) ? 1 : 0;
        r.nwr  = skip ? 0 : N;
        r.nrd  = N;
        exp_res.push_back(r);
    endtask

    task automatic start_dut(input bit skip);
        @(negedge i_clk);
        i_start = 1'b1; i_skip_fill = skip;
        @(negedge i_clk);
        i_start = 1'b0; i_skip_fill = 1'b0;
    endtask

    task automatic run(input bit skip, input int poke);
        bit fin = 0;
        int edges = 0;
        expect_run(skip);
        start_dut(skip);
        for (int k = 0; k < 3000; k++) begin
            @(negedge i_clk);
            i_start = (k == poke);
            i_skip_fill = (k == poke);
            if (o_done && !o_busy) begin
                fin = 1; edges = k + 1;
                break;
            end
        end
        i_start = 1'b0; i_skip_fill = 1'b0;
        check("done_reached", fin, 1);
        if (fin && !rnd_mode) check("latency", edges, skip ? (N + 2) : 2 * (N + 2));
        if (!fin) begin
            exp_wr.delete(); exp_rd.delete(); exp_res.delete();
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bus"}, {wb.cyc, wb.stb, wb.we, wb.adr, wb.dat_w}, 0);
        check({tag, "_status"}, {o_busy, o_done, o_pass, o_err_count, o_err_addr}, 0);
        check({tag, "_sel"}, wb.sel, 1);
    endtask

    task automatic clear_corrupt();
        for (int a = 0; a < N; a++) corrupt[a] = 0;
    endtask

    initial begin : stim
        bit found;
        clear_corrupt();
        for (int a = 0; a < N; a++) ref_mem[a] = '0;
        repeat (3) @(negedge i_clk);
        check_zero("reset");
        #2 i_reset_n = 1'b1;
        @(negedge i_clk);

        run(0, -1);

        corrupt[3] = 1; corrupt[9] = 1;
        run(0, -1);
        clear_corrupt();

        rnd_mode = 1;
        repeat (3) run(0, -1);
        corrupt[$urandom_range(0, N - 1)] = 1;
        corrupt[$urandom_range(0, N - 1)] = 1;
        run(0, -1);
        clear_corrupt();
        rnd_mode = 0;

        @(negedge i_clk); #2 zero_req = 1;
        @(negedge i_clk); #2 zero_req = 0;
        for (int a = 0; a < N; a++) ref_mem[a] = '0;
        run(1, -1);

        // Abort during the read phase, then a fresh run must pass
        expect_run(0);
        start_dut(0);
        found = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge i_clk);
            if (wb.cyc && wb.stb && !wb.we && wb.adr == 7) begin found = 1; break; end
        end
        check("reach_rd7", found, 1);
        #3 i_reset_n = 1'b0;
        #1 check_zero("midrst");
        exp_wr.delete(); exp_rd.delete(); exp_res.delete();
        repeat (2) @(negedge i_clk);
        #2 i_reset_n = 1'b1;
        @(negedge i_clk);
        run(0, -1);

        // Start pulse during the read phase must be ignored
        corrupt[5] = 1;
        run(0, 25);
        clear_corrupt();

        @(negedge i_clk); #2 stray = 1'b1;
        @(negedge i_clk); #2 stray = 1'b0;
        repeat (2) @(negedge i_clk);
        check("stray_err_count", o_err_count, 1);
        check("stray_err_addr", o_err_addr, 5);
        check("stray_done", o_done, 1);
        check("stray_pass", o_pass, 0);
        run(0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
